// File: rtl/op_memory_scanner.sv
// Scans the 128-entry operational memory through its gl read port once per next_screen
// pulse and streams the active square descriptors to the renderer over valid/ready.
module op_memory_scanner #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 11,
   parameter int DEPTH      = 128,
   parameter int ACTIVE_BIT = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_next_screen,
   output logic [ADDR_W-1:0] o_address_read_gl,
   input  logic [DATA_W-1:0] i_data_read_gl,
   output logic              o_new_state,
   output logic              o_sq_valid,
   input  logic              i_sq_ready,
   output logic [DATA_W-1:0] o_sq_data,
   output logic [ADDR_W-1:0] o_sq_index,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [ADDR_W:0]   o_sq_count,
   output logic              o_overrun
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_SCAN, S_DRAIN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ia;
   logic [ADDR_W-1:0] r_pipe_idx;
   logic              r_in_flight;
   logic [DATA_W-1:0] r_fifo_data [2];
   logic [ADDR_W-1:0] r_fifo_idx  [2];
   logic              r_rd_ptr;
   logic              r_wr_ptr;
   logic [1:0]        r_fifo_cnt;
   logic [ADDR_W:0]   r_run_cnt;
   logic [ADDR_W:0]   r_sq_count;
   logic              r_busy;
   logic              r_new_state;
   logic              r_frame_done;
   logic              r_overrun;
   logic              r_post_rst;

   logic       w_push;
   logic       w_pop;
   logic [1:0] w_cnt_next;
   logic [1:0] w_credit;
   logic       w_issue;
   logic       w_last;

   assign w_push     = r_in_flight & i_data_read_gl[ACTIVE_BIT];
   assign w_pop      = (r_fifo_cnt != 2'd0) & i_sq_ready;
   assign w_cnt_next = r_fifo_cnt + 2'(w_push) - 2'(w_pop);
   // Credit counts the entry leaving this cycle as free, so a streaming renderer sees one
   // issue per clock while the 2-deep FIFO can never be overfilled when it stalls.
   assign w_credit   = r_fifo_cnt - 2'(w_pop) + 2'(r_in_flight);
   assign w_issue    = (r_state == S_SCAN) && (w_credit < 2'd2);
   assign w_last     = (r_ia == ADDR_W'(DEPTH - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ia         <= '0;
         r_pipe_idx   <= '0;
         r_in_flight  <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_wr_ptr     <= 1'b0;
         r_fifo_cnt   <= 2'd0;
         r_run_cnt    <= '0;
         r_sq_count   <= '0;
         r_busy       <= 1'b0;
         r_new_state  <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
         r_post_rst   <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            r_fifo_data[k] <= '0;
            r_fifo_idx[k]  <= '0;
         end
      end else begin
         r_new_state  <= 1'b0;
         r_frame_done <= 1'b0;
         // First clock after reset hands the read port back to the editor.
         if (!r_post_rst) begin
            r_post_rst  <= 1'b1;
            r_new_state <= 1'b1;
         end
         if (i_next_screen && r_state != S_IDLE)
            r_overrun <= 1'b1;

         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= i_data_read_gl;
            r_fifo_idx[r_wr_ptr]  <= r_pipe_idx;
            r_wr_ptr              <= ~r_wr_ptr;
            r_run_cnt             <= r_run_cnt + (ADDR_W+1)'(1);
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_fifo_cnt  <= w_cnt_next;
         r_in_flight <= w_issue;
         if (w_issue)
            r_pipe_idx <= r_ia;

         case (r_state)
            S_IDLE: begin
               if (i_next_screen) begin
                  r_state   <= S_ARM;
                  r_busy    <= 1'b1;
                  r_ia      <= '0;
                  r_run_cnt <= '0;
               end
            end
            S_ARM: r_state <= S_SCAN;
            S_SCAN: begin
               if (w_issue) begin
                  if (w_last) r_state <= S_DRAIN;
                  else        r_ia    <= r_ia + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               if (!r_in_flight && w_cnt_next == 2'd0) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_new_state  <= 1'b1;
                  r_frame_done <= 1'b1;
                  r_sq_count   <= r_run_cnt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_address_read_gl = r_ia;
   assign o_new_state       = r_new_state;
   assign o_sq_valid        = (r_fifo_cnt != 2'd0);
   assign o_sq_data         = r_fifo_data[r_rd_ptr];
   assign o_sq_index        = r_fifo_idx[r_rd_ptr];
   assign o_busy            = r_busy;
   assign o_frame_done      = r_frame_done;
   assign o_sq_count        = r_sq_count;
   assign o_overrun         = r_overrun;

endmodule

// File: tb/tb_op_memory_scanner.sv
// Bench for op_memory_scanner: a registered-read memory model, a table of scan passes and
// hand-written reset sequences.
module tb_op_memory_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        next_screen;
   logic [6:0]  address_read_gl;
   logic [10:0] data_read_gl;
   logic        new_state;
   logic        sq_valid;
   logic        sq_ready;
   logic [10:0] sq_data;
   logic [6:0]  sq_index;
   logic        busy;
   logic        frame_done;
   logic [7:0]  sq_count;
   logic        overrun;

   logic [10:0] mem [128];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) data_read_gl <= mem[address_read_gl];

   op_memory_scanner dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_next_screen     (next_screen),
      .o_address_read_gl (address_read_gl),
      .i_data_read_gl    (data_read_gl),
      .o_new_state       (new_state),
      .o_sq_valid        (sq_valid),
      .i_sq_ready        (sq_ready),
      .o_sq_data         (sq_data),
      .o_sq_index        (sq_index),
      .o_busy            (busy),
      .o_frame_done      (frame_done),
      .o_sq_count        (sq_count),
      .o_overrun         (overrun)
   );

   typedef struct {
      int pat;    // memory fill pattern
      int rmode;  // 0: ready always 1, 1: ready 1,0,0,1 repeating
      int inj;    // edge index of an extra next_screen, -1 for none
      int cnt;    // expected sq_count
      int done;   // expected frame_done cycle, -1 to skip
      int first;  // expected first sq_valid cycle, -1 for never
      int ov;     // expected overrun after the pass
   } scen_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic set_mem(input int pat);
      for (int i = 0; i < 128; i++) begin
         case (pat)
            0: mem[i] = 11'(i) & 11'h3FF;
            1: mem[i] = 11'h400 | (11'(i * 7) & 11'h3FF);
            2: mem[i] = 11'(i * 5) & 11'h3FF;
            default: mem[i] = (i % 2 == 0) ? (11'h400 | 11'(i)) : 11'(i);
         endcase
      end
      if (pat == 0) begin
         mem[3]   = 11'h403;
         mem[64]  = 11'h440;
         mem[127] = 11'h7FF;
      end
   endtask

   task automatic run_pass(input int row, input scen_t s);
      logic [17:0] expq [$];
      logic [17:0] e;
      int done_c, first_c, stall_err, ns_err, restart_err, beats;
      logic busy0, held, rdy;
      logic [10:0] hd;
      logic [6:0] hi;
      set_mem(s.pat);
      expq = {};
      for (int i = 0; i < 128; i++)
         if (mem[i][10]) expq.push_back({7'(i), mem[i]});
      done_c = -1; first_c = -1; stall_err = 0; ns_err = 0; restart_err = 0; beats = 0;
      held = 1'b0; hd = '0; hi = '0; busy0 = 1'b0;
      @(negedge clk);
      next_screen = 1'b1;
      sq_ready    = 1'b1;
      for (int c = 0; c < 400 && (done_c < 0 || c <= done_c + 2); c++) begin
         @(negedge clk);
         next_screen = (c + 1 == s.inj);
         if (c == 0) busy0 = busy;
         if (new_state !== frame_done) ns_err++;
         if (frame_done && done_c < 0) done_c = c;
         if (done_c >= 0 && c > done_c && busy) restart_err++;
         if (sq_valid && first_c < 0) first_c = c;
         if (held && (!sq_valid || sq_data !== hd || sq_index !== hi)) stall_err++;
         rdy = (s.rmode == 0) ? 1'b1 : (c % 4 == 0 || c % 4 == 3);
         sq_ready = rdy;
         held = sq_valid && !rdy;
         hd = sq_data;
         hi = sq_index;
         if (sq_valid && rdy) begin
            beats++;
            if (expq.size() == 0) begin
               chk("extra_beat", 32'(sq_index), 32'hFFFF);
            end else begin
               e = expq.pop_front();
               chk("beat_index", 32'(sq_index), 32'(e[17:11]));
               chk("beat_data", 32'(sq_data), 32'(e[10:0]));
            end
         end
      end
      next_screen = 1'b0;
      sq_ready    = 1'b1;
      chk("frame_done_seen", 32'(done_c >= 0), 32'd1);
      if (s.done >= 0) chk("frame_done_cycle", 32'(done_c), 32'(s.done));
      chk("first_valid_cycle", 32'(first_c), 32'(s.first));
      chk("sq_count", 32'(sq_count), 32'(s.cnt));
      chk("beat_total", 32'(beats), 32'(s.cnt));
      chk("missing_beats", 32'(expq.size()), 32'd0);
      chk("new_state_eq_frame_done", 32'(ns_err), 32'd0);
      chk("busy_at_arm", 32'(busy0), 32'd1);
      chk("no_restart", 32'(restart_err), 32'd0);
      chk("overrun", 32'(overrun), 32'(s.ov));
      if (s.rmode == 1) chk("stall_stable", 32'(stall_err), 32'd0);
      $display("pass row=%0d pat=%0d beats=%0d frame_done_cycle=%0d sq_count=%0d overrun=%0b",
               row, s.pat, beats, done_c, sq_count, overrun);
   endtask

   task automatic check_idle_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_sq_valid"}, 32'(sq_valid), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun), 32'd0);
      chk({tag, "_sq_count"}, 32'(sq_count), 32'd0);
      chk({tag, "_new_state"}, 32'(new_state), 32'd0);
      chk({tag, "_address"}, 32'(address_read_gl), 32'd0);
   endtask

   initial begin
      scen_t tbl [7];
      tbl[0] = '{pat: 0, rmode: 0, inj: -1,  cnt: 3,   done: 131, first: 6,  ov: 0};
      tbl[1] = '{pat: 1, rmode: 1, inj: -1,  cnt: 128, done: -1,  first: 3,  ov: 0};
      tbl[2] = '{pat: 2, rmode: 0, inj: -1,  cnt: 0,   done: -1,  first: -1, ov: 0};
      tbl[3] = '{pat: 1, rmode: 0, inj: -1,  cnt: 128, done: 131, first: 3,  ov: 0};
      tbl[4] = '{pat: 0, rmode: 0, inj: 131, cnt: 3,   done: 131, first: 6,  ov: 1};
      tbl[5] = '{pat: 3, rmode: 0, inj: 10,  cnt: 64,  done: -1,  first: 3,  ov: 1};
      tbl[6] = '{pat: 0, rmode: 0, inj: -1,  cnt: 3,   done: 131, first: 6,  ov: 1};

      rst_n = 1'b0;
      next_screen = 1'b0;
      sq_ready = 1'b1;
      set_mem(2);
      repeat (3) @(negedge clk);
      check_idle_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_new_state_hi", 32'(new_state), 32'd1);
      chk("post_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("post_reset_new_state_lo", 32'(new_state), 32'd0);

      for (int r = 0; r < 7; r++) run_pass(r, tbl[r]);

      // Reset in the middle of a pass.
      set_mem(1);
      @(negedge clk);
      next_screen = 1'b1;
      @(negedge clk);
      next_screen = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_pass_busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_reset("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_reset_new_state_hi", 32'(new_state), 32'd1);
      @(negedge clk);
      chk("mid_reset_new_state_lo", 32'(new_state), 32'd0);
      run_pass(7, '{pat: 1, rmode: 0, inj: -1, cnt: 128, done: 131, first: 3, ov: 0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/op_memory_scanner.md
Name: op_memory_scanner

Overview:
- Read-side client of the 128 x 11-bit operational memory, on the graphics ("gl") port.
- On each `next_screen` pulse it walks all memory addresses in order and accounts for the memory's one-cycle registered read latency.
- It drops inactive entries and streams active square descriptors to the renderer over a valid/ready interface.
- At the end of a pass it pulses `new_state`, which hands the memory's read port back to the editor.

Parameters:
- ADDR_W, 7, memory address width
- DATA_W, 11, memory word width
- DEPTH, 128, number of entries scanned per pass (≤ 2^ADDR_W)
- ACTIVE_BIT, 10, bit of the entry word marking the square as present

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- next_screen  in  1  one-cycle pulse that starts a pass; also wired to the memory
- address_read_gl  out  ADDR_W  read address driven to the memory gl port
- data_read_gl  in  DATA_W  registered memory output; valid the cycle after its address is presented
- new_state  out  1  one-cycle pulse returning the memory to editor reads
- sq_valid  out  1  descriptor available
- sq_ready  in  1  renderer accepts the descriptor
- sq_data  out  DATA_W  entry word, passed unmodified
- sq_index  out  ADDR_W  address the entry came from
- busy  out  1  pass in progress
- frame_done  out  1  one-cycle pulse at end of pass, coincident with new_state
- sq_count  out  ADDR_W+1  active entries found in the last completed pass
- overrun  out  1  sticky; a `next_screen` arrived while busy

Behaviour:
- Reset (async, rst_n=0) values:
  - state = IDLE
  - address_read_gl = 0
  - sq_valid, busy, frame_done, overrun = 0
  - sq_count = 0, FIFO empty
  - new_state = 0 during reset; asserted for exactly one cycle on the first clock after rst_n rises, so the memory returns to editor mode.
- States: IDLE → ARM → SCAN → DRAIN → IDLE.
- IDLE:
  - On next_screen=1, go to ARM and set busy=1.
  - The memory enables gl reads on the same edge.
- ARM: one cycle. Present address 0; go to SCAN.
- SCAN:
  - Issue counter `ia` holds the next address to present.
  - A 1-bit in_flight flag records that an address was presented last cycle.
  - Issue rule: present `ia` and increment it only if (fifo_count + in_flight) < 2. Otherwise hold the address and do not mark it in flight.
  - Each cycle in_flight=1: capture data_read_gl together with the matching index.
    - If bit ACTIVE_BIT = 1, push the pair into the 2-entry FIFO and increment the running count.
    - Otherwise discard the word.
  - After address DEPTH-1 has been issued, go to DRAIN.
- DRAIN:
  - Wait until in_flight = 0 and the FIFO is empty.
  - Then, in a single cycle: pulse new_state and frame_done, latch sq_count from the running count, clear busy, return to IDLE.
- Output side:
  - sq_valid = FIFO non-empty.
  - sq_data and sq_index come from the FIFO head.
  - A pop occurs when sq_valid && sq_ready.
  - While sq_valid=1 and sq_ready=0, sq_data and sq_index stay stable.
  - Push and pop in the same cycle are both honoured.
- Throughput: with sq_ready held at 1, one address is issued per cycle and a full pass takes DEPTH + 3 cycles from next_screen to frame_done.
- Latency: first possible sq_valid is 3 cycles after next_screen (ARM, address 0 issued, data captured).
- next_screen while busy: ignored, the pass is not restarted, and overrun is set to 1. overrun clears only on reset.
- next_screen in the same cycle as the DRAIN completion: ignored and flags overrun. No back-to-back restart in that cycle.
- No active entries in a pass: no sq_valid; sq_count = 0; frame_done still pulses.
- All entries active: sq_count = DEPTH. The width holds 128.
- Address counter does not wrap within a pass. It resets to 0 at ARM.
- Reset asserted mid-pass: everything aborts immediately and the FIFO is flushed; the post-reset new_state pulse restores editor mode.

Test Plan:
- Reset release → new_state high exactly one cycle after rst_n rises; all other outputs 0.
- Memory with entries 3, 64, 127 active (values 0x400|3, 0x400|64, 0x7FF); next_screen; sq_ready=1 → three beats (index/data): 3/0x403, 64/0x440, 127/0x7FF; frame_done at cycle 131 after next_screen; sq_count=3.
- All entries active; sq_ready toggling 1,0,0,1… → 128 beats in index order with none dropped or duplicated; data held stable while stalled; sq_count=128.
- All entries inactive → no sq_valid; frame_done and new_state pulse together; sq_count=0.
- Second next_screen 10 cycles into a pass → pass completes unchanged and overrun=1; after that, a next_screen in IDLE starts a new pass normally.
- rst_n pulsed low at cycle 50 of a pass → busy=0 and sq_valid=0 immediately; new_state pulse after release; the next pass produces the full correct sequence.
